round_key_store: RTL

ROUND_KEY_STORE -- requirements
Module: round_key_store

---
 rtl/round_key_store_pkg.sv | 49 ++++
 rtl/rks_mem.sv | 58 +++++
 rtl/round_key_store.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/round_key_store_pkg.sv
// ---------------------------------------------------------------------------
// round_key_store_pkg
// Shared definitions for the AES round-key store:
//   - default round-key width and storage depth
//   - key-size (mode) encodings and the round-key count lookup (11/13/15)
//   - controller state encoding
// Optional feature macro used by this block: ROUND_KEY_STORE_ZEROIZE_EN
// ---------------------------------------------------------------------------
package round_key_store_pkg;

  localparam int RKS_KEY_W  = 128;
  localparam int RKS_MAX_RK = 15;
  localparam int RKS_PTR_W  = 4;

  typedef enum logic [1:0] {
    MODE_AES128 = 2'd0,
    MODE_AES192 = 2'd1,
    MODE_AES256 = 2'd2,
    MODE_RSVD   = 2'd3
  } rks_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_READY  = 2'd2,
    ST_REPLAY = 2'd3
  } rks_state_e;

  // Number of round keys (Nr+1) per key size.
  localparam logic [RKS_PTR_W-1:0] NRK_AES128 = 4'd11;
  localparam logic [RKS_PTR_W-1:0] NRK_AES192 = 4'd13;
  localparam logic [RKS_PTR_W-1:0] NRK_AES256 = 4'd15;

  function automatic logic mode_valid(input logic [1:0] mode);
    return (mode != MODE_RSVD);
  endfunction

  function automatic logic [RKS_PTR_W-1:0] nrk_lookup(input logic [1:0] mode);
    logic [RKS_PTR_W-1:0] n;
    case (mode)
      MODE_AES128: n = NRK_AES128;
      MODE_AES192: n = NRK_AES192;
      MODE_AES256: n = NRK_AES256;
      default:     n = 4'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rks_mem.sv
// ---------------------------------------------------------------------------
// rks_mem
// Round-key storage array: one synchronous write port, one asynchronous
// read port.
// Ports:
//   clk            - clock, writes on rising edge
//   rst_n, clr     - (ROUND_KEY_STORE_ZEROIZE_EN only) async reset / sync
//                    clear that wipe every entry to zero
//   we/waddr/wdata - write port
//   raddr/rdata    - combinational read port
// Without ROUND_KEY_STORE_ZEROIZE_EN the array has no reset at all.
// ---------------------------------------------------------------------------
module rks_mem #(
  parameter int W     = 128,
  parameter int DEPTH = 15,
  parameter int AW    = 4
) (
  input  logic          clk,
`ifdef ROUND_KEY_STORE_ZEROIZE_EN
  input  logic          rst_n,
  input  logic          clr,
`endif
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_r [DEPTH];

`ifdef ROUND_KEY_STORE_ZEROIZE_EN
  // Storage write with zeroize on reset and on a clear request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end
`else
  // Reset-free storage write; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end
`endif

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/round_key_store.sv
// ---------------------------------------------------------------------------
// round_key_store
// Buffers the Nr+1 round keys produced by an AES key expansion and replays
// them in forward (round 0..Nr) or reverse (Nr..0) order through a
// valid/ready interface.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   mode, start           - key size (0/1/2 = AES-128/192/256, 3 reserved),
//                           start a new fill (aborts anything in flight)
//   wr_valid, wr_key      - round keys in ascending round order
//   rd_start, rev         - begin a replay, direction sampled with rd_start
//   rd_ready              - consumer accepts rd_key this cycle
//   rd_valid, rd_key,
//   rd_round              - replay output (registered)
//   full, busy, done, err - status (registered); err is sticky
// Optional macro: ROUND_KEY_STORE_ZEROIZE_EN wipes the key storage on reset
// and on every valid start.
// ---------------------------------------------------------------------------
module round_key_store
  import round_key_store_pkg::*;
#(
  parameter int KEY_W  = RKS_KEY_W,
  parameter int MAX_RK = RKS_MAX_RK
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  input  logic                 start,
  input  logic                 wr_valid,
  input  logic [KEY_W-1:0]     wr_key,
  input  logic                 rd_start,
  input  logic                 rev,
  input  logic                 rd_ready,
  output logic                 rd_valid,
  output logic [KEY_W-1:0]     rd_key,
  output logic [RKS_PTR_W-1:0] rd_round,
  output logic                 full,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  rks_state_e             state_r, state_nx_s;
  logic [RKS_PTR_W-1:0]   nrk_r, nrk_nx_s;
  logic [RKS_PTR_W-1:0]   wr_ptr_r, wr_ptr_nx_s;
  logic [RKS_PTR_W-1:0]   rd_ptr_r, rd_ptr_nx_s;
  logic                   rev_r, rev_nx_s;
  logic                   full_r, full_nx_s;
  logic                   err_r, err_nx_s;
  logic                   done_r, done_nx_s;
  logic                   busy_r, busy_nx_s;
  logic                   rd_valid_r, rd_valid_nx_s;
  logic [KEY_W-1:0]       rd_key_r, rd_key_nx_s;
  logic [RKS_PTR_W-1:0]   rd_round_r, rd_round_nx_s;
  logic [RKS_PTR_W-1:0]   last_wr_s, last_rd_s;
  logic                   mem_we_s;
  logic [KEY_W-1:0]       mem_rdata_s;

  assign last_wr_s = nrk_r - 4'd1;
  assign last_rd_s = rev_r ? 4'd0 : (nrk_r - 4'd1);

  // The read port looks at the *next* pointer so that rd_key can be
  // registered and still line up with rd_round on the following cycle.
`ifdef ROUND_KEY_STORE_ZEROIZE_EN
  logic mem_clr_s;
  assign mem_clr_s = start && mode_valid(mode);

  rks_mem #(.W(KEY_W), .DEPTH(MAX_RK), .AW(RKS_PTR_W)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mem_clr_s),
    .we    (mem_we_s),
    .waddr (wr_ptr_r),
    .wdata (wr_key),
    .raddr (rd_ptr_nx_s),
    .rdata (mem_rdata_s)
  );
`else
  rks_mem #(.W(KEY_W), .DEPTH(MAX_RK), .AW(RKS_PTR_W)) u_mem (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (wr_ptr_r),
    .wdata (wr_key),
    .raddr (rd_ptr_nx_s),
    .rdata (mem_rdata_s)
  );
`endif

  // Controller: next state, pointers, flags and storage write enable.
  always_comb begin
    state_nx_s    = state_r;
    nrk_nx_s      = nrk_r;
    wr_ptr_nx_s   = wr_ptr_r;
    rd_ptr_nx_s   = rd_ptr_r;
    rev_nx_s      = rev_r;
    full_nx_s     = full_r;
    err_nx_s      = err_r;
    rd_valid_nx_s = rd_valid_r;
    done_nx_s     = 1'b0;
    mem_we_s      = 1'b0;
    if (start) begin
      // start overrides everything else in the same cycle
      rd_valid_nx_s = 1'b0;
      wr_ptr_nx_s   = 4'd0;
      rd_ptr_nx_s   = 4'd0;
      full_nx_s     = 1'b0;
      if (mode_valid(mode)) begin
        nrk_nx_s   = nrk_lookup(mode);
        err_nx_s   = 1'b0;
        state_nx_s = ST_FILL;
      end else begin
        err_nx_s   = 1'b1;
        state_nx_s = ST_IDLE;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nx_s = ST_IDLE;
        end
        ST_FILL: begin
          if (wr_valid) begin
            mem_we_s    = 1'b1;
            wr_ptr_nx_s = wr_ptr_r + 4'd1;
            if (wr_ptr_r == last_wr_s) begin
              state_nx_s = ST_READY;
              full_nx_s  = 1'b1;
            end else begin
              state_nx_s = ST_FILL;
            end
          end else begin
            state_nx_s = ST_FILL;
          end
        end
        ST_READY: begin
          if (wr_valid) begin
            err_nx_s = 1'b1;
          end else begin
            err_nx_s = err_r;
          end
          if (rd_start) begin
            state_nx_s    = ST_REPLAY;
            rev_nx_s      = rev;
            rd_ptr_nx_s   = rev ? (nrk_r - 4'd1) : 4'd0;
            rd_valid_nx_s = 1'b1;
          end else begin
            state_nx_s = ST_READY;
          end
        end
        ST_REPLAY: begin
          if (wr_valid) begin
            err_nx_s = 1'b1;
          end else begin
            err_nx_s = err_r;
          end
          if (rd_valid_r && rd_ready) begin
            if (rd_ptr_r == last_rd_s) begin
              // last key handed over: pointer stays put, no wrap
              state_nx_s    = ST_READY;
              done_nx_s     = 1'b1;
              rd_valid_nx_s = 1'b0;
            end else begin
              rd_ptr_nx_s = rev_r ? (rd_ptr_r - 4'd1) : (rd_ptr_r + 4'd1);
            end
          end else begin
            state_nx_s = ST_REPLAY;
          end
        end
        default: begin
          state_nx_s    = ST_IDLE;
          rd_valid_nx_s = 1'b0;
        end
      endcase
    end
  end

  // Replay data register inputs; outputs read as zero when not valid.
  always_comb begin
    rd_key_nx_s   = {KEY_W{1'b0}};
    rd_round_nx_s = 4'd0;
    if (rd_valid_nx_s) begin
      rd_key_nx_s   = mem_rdata_s;
      rd_round_nx_s = rd_ptr_nx_s;
    end else begin
      rd_key_nx_s   = {KEY_W{1'b0}};
      rd_round_nx_s = 4'd0;
    end
  end

  assign busy_nx_s = (state_nx_s == ST_FILL) || (state_nx_s == ST_REPLAY);

  // Controller state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      nrk_r      <= 4'd0;
      wr_ptr_r   <= 4'd0;
      rd_ptr_r   <= 4'd0;
      rev_r      <= 1'b0;
      full_r     <= 1'b0;
      err_r      <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_key_r   <= {KEY_W{1'b0}};
      rd_round_r <= 4'd0;
    end else begin
      state_r    <= state_nx_s;
      nrk_r      <= nrk_nx_s;
      wr_ptr_r   <= wr_ptr_nx_s;
      rd_ptr_r   <= rd_ptr_nx_s;
      rev_r      <= rev_nx_s;
      full_r     <= full_nx_s;
      err_r      <= err_nx_s;
      done_r     <= done_nx_s;
      busy_r     <= busy_nx_s;
      rd_valid_r <= rd_valid_nx_s;
      rd_key_r   <= rd_key_nx_s;
      rd_round_r <= rd_round_nx_s;
    end
  end

  assign rd_valid = rd_valid_r;
  assign rd_key   = rd_key_r;
  assign rd_round = rd_round_r;
  assign full     = full_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;

endmodule
